// File: rtl/pet_video_capture.sv
// PET TTL video capture: recovers dot/line position from sync edges and packs the
// active pixel window into byte-wide frame-buffer writes with linear addresses.
module pet_video_capture #(
  parameter int H_START  = 64,
  parameter int H_ACTIVE = 320,
  parameter int V_START  = 20,
  parameter int V_ACTIVE = 200,
  parameter int ADDR_W   = 13
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              DOT_CE,
  input  logic              PET_VID_DATA_N,
  input  logic              PET_VID_HORZ_N,
  input  logic              PET_VID_VERT_N,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              FRAME_DONE,
  output logic              LOCKED,
  output logic              LINE_ERR
);

  localparam logic [9:0]        H_LO       = 10'(H_START);
  localparam logic [9:0]        H_HI       = 10'(H_START + H_ACTIVE);
  localparam logic [8:0]        V_LO       = 9'(V_START);
  localparam logic [8:0]        V_HI       = 9'(V_START + V_ACTIVE);
  localparam logic [8:0]        V_LAST     = 9'(V_START + V_ACTIVE - 1);
  localparam logic [6:0]        LAST_BYTE  = 7'(H_ACTIVE / 8 - 1);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(H_ACTIVE / 8);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECK, ST_LOCKED} lock_t;

  logic [2:0]        sync1, sync2;  // {data, horz, vert}
  logic              h_prev, v_prev;
  logic [9:0]        dot_cnt;
  logic [8:0]        line_cnt;
  logic [8:0]        prev_total;
  logic [ADDR_W-1:0] line_base;
  logic [6:0]        shreg;
  lock_t             lock_st;

  logic       hedge, vedge, line_act, dot_act, line_open, capture, byte_done, last_byte, good;
  logic [9:0] rel;
  logic [7:0] next_byte;

  always_comb begin
    hedge     = DOT_CE & h_prev & ~sync2[1];
    vedge     = DOT_CE & v_prev & ~sync2[0];
    line_act  = (line_cnt >= V_LO) && (line_cnt < V_HI);
    dot_act   = (dot_cnt >= H_LO) && (dot_cnt < H_HI);
    line_open = line_act && (dot_cnt < H_HI);
    rel       = dot_cnt - H_LO;
    next_byte = {shreg, ~sync2[2]};
    // The sync-edge dot itself is never captured; it restarts the position.
    capture   = DOT_CE && !hedge && !vedge && line_act && dot_act;
    byte_done = capture && (rel[2:0] == 3'd7);
    last_byte = (rel[9:3] == LAST_BYTE);
    good      = (line_cnt == prev_total) && (line_cnt >= V_HI);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1      <= '1;
      sync2      <= '1;
      h_prev     <= 1'b1;
      v_prev     <= 1'b1;
      dot_cnt    <= '1;
      line_cnt   <= '1;
      line_base  <= '0;
      shreg      <= '0;
      WR_STB     <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
      FRAME_DONE <= 1'b0;
      LINE_ERR   <= 1'b0;
    end else begin
      sync1      <= {PET_VID_DATA_N, PET_VID_HORZ_N, PET_VID_VERT_N};
      sync2      <= sync1;
      WR_STB     <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (DOT_CE) begin
        h_prev <= sync2[1];
        v_prev <= sync2[0];

        if (hedge)               dot_cnt <= '0;
        else if (dot_cnt != '1)  dot_cnt <= dot_cnt + 10'd1;

        if (vedge)                         line_cnt <= '0;
        else if (hedge && line_cnt != '1)  line_cnt <= line_cnt + 9'd1;

        if ((hedge || vedge) && line_open) LINE_ERR <= 1'b1;

        // A truncated line still consumes its full address span.
        if (vedge)
          line_base <= '0;
        else if ((hedge && line_open) || (byte_done && last_byte))
          line_base <= line_base + LINE_BYTES;

        if (capture) shreg <= next_byte[6:0];

        if (byte_done) begin
          WR_STB     <= 1'b1;
          WR_ADDR    <= line_base + ADDR_W'(rel[9:3]);
          WR_DATA    <= next_byte;
          FRAME_DONE <= last_byte && (line_cnt == V_LAST);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_st    <= ST_UNLOCKED;
      prev_total <= '0;
      LOCKED     <= 1'b0;
    end else if (vedge) begin
      prev_total <= line_cnt;
      if (!good) begin
        lock_st <= ST_UNLOCKED;
        LOCKED  <= 1'b0;
      end else begin
        case (lock_st)
          ST_UNLOCKED: begin
            lock_st <= ST_CHECK;
            LOCKED  <= 1'b0;
          end
          default: begin
            lock_st <= ST_LOCKED;
            LOCKED  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pet_video_capture.sv
// Bench for pet_video_capture: frame-level stimulus, expected writes queued from a
// line/byte model, monitor compares each WR_STB against the queue.
module tb_pet_video_capture;
  localparam int HS = 4, HA = 16, VS = 2, VA = 3, AW = 13, NB = HA / 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          dot_ce;
  logic          data_n = 1'b1, horz_n = 1'b1, vert_n = 1'b1;
  logic          wr_stb, frame_done, locked, line_err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  int unsigned   ce_cnt = 0;
  int            tests = 0, fails = 0;

  typedef struct {int addr; int data; bit fd;} wr_t;
  wr_t exp_q[$];

  bit m_synced = 1'b0, m_err = 1'b0;
  int m_prev = 0, m_run = 0, m_lines = 0;

  pet_video_capture #(
    .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .ADDR_W(AW)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .DOT_CE(dot_ce),
    .PET_VID_DATA_N(data_n), .PET_VID_HORZ_N(horz_n), .PET_VID_VERT_N(vert_n),
    .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .FRAME_DONE(frame_done), .LOCKED(locked), .LINE_ERR(line_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) ce_cnt <= (ce_cnt == 3) ? 0 : ce_cnt + 1;
  assign dot_ce = (ce_cnt == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), e.addr);
        chk("wr_data", 32'(wr_data), e.data);
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end else if (rst_n && frame_done) begin
      tests++;
      fails++;
      $display("FAIL frame_done_alone: got 1 expected 0 without WR_STB");
    end
  end

  // One dot period: pins change just after a DOT_CE and are sampled at the next one.
  task automatic slot(input bit d, input bit h, input bit v);
    data_n = d; horz_n = h; vert_n = v;
    @(posedge clk iff dot_ce);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_wr_stb", 32'(wr_stb), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_line_err", 32'(line_err), 0);
  endtask

  // mode: 0 random pixels, 1 all lit, 2 only first active dot lit
  task automatic frame(input int nl, input int mode, input int short_line,
                       input bit rnd_short, input int rst_line);
    int total, len;
    bit good;
    bit pix_n [64];
    logic [7:0] byt;
    wr_t w;
    total = m_synced ? m_lines - 1 : 511;
    good  = (total == m_prev) && (total >= VS + VA);
    m_run = good ? m_run + 1 : 0;
    m_prev = total;
    m_synced = 1'b1;
    m_lines = nl;
    for (int li = 0; li < nl; li++) begin
      if (li == short_line) len = 14;
      else if (rnd_short && $urandom_range(0, 3) == 0) len = $urandom_range(3, 23);
      else len = 24;
      for (int s = 0; s < len; s++)
        pix_n[s] = (mode == 1) ? 1'b0 : (mode == 2) ? (s != HS + 1) : 1'($urandom_range(0, 1));
      if (m_synced && li != rst_line && li >= VS && li < VS + VA) begin
        for (int b = 0; b < NB; b++) begin
          if (HS + 8 * b + 7 <= len - 2) begin
            byt = '0;
            for (int k = 0; k < 8; k++) byt = {byt[6:0], ~pix_n[HS + 8 * b + k + 1]};
            w.addr = (li - VS) * NB + b;
            w.data = int'(byt);
            w.fd   = (li == VS + VA - 1) && (b == NB - 1);
            exp_q.push_back(w);
          end
        end
        if (len - 1 < HS + HA) m_err = 1'b1;
      end
      for (int s = 0; s < len; s++) begin
        slot(pix_n[s], s >= 2, !(li == 0 && s < 2));
        if (li == 0 && s == 0) begin
          chk("locked", 32'(locked), 32'(m_run >= 2));
          chk("line_err", 32'(line_err), 32'(m_err));
        end
        if (li == rst_line && s == HS + 5) begin
          rst_n = 1'b0;
          #1;
          check_reset_outputs();
          chk("queue_at_reset", exp_q.size(), 0);
          exp_q.delete();
          m_synced = 1'b0; m_err = 1'b0; m_prev = 0; m_run = 0;
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk iff dot_ce);
    @(negedge clk);
    repeat (4) slot(1'b1, 1'b1, 1'b1);

    frame(6, 1, -1, 1'b0, -1);   // full frame, all lit
    frame(6, 2, -1, 1'b0, -1);   // pixel order
    frame(6, 0, -1, 1'b0, -1);
    frame(6, 0, -1, 1'b0, -1);   // lock reached at this closing edge
    frame(5, 0, -1, 1'b0, -1);   // short frame drops lock at next edge
    frame(6, 0, 2, 1'b0, -1);    // truncated line 2
    frame(6, 0, -1, 1'b0, 3);    // reset mid-line
    frame(6, 0, -1, 1'b0, -1);
    for (int f = 0; f < 8; f++)
      frame($urandom_range(4, 8), 0, -1, 1'b1, -1);
    frame(6, 0, -1, 1'b0, -1);
    frame(6, 0, -1, 1'b0, -1);
    frame(1, 0, -1, 1'b0, -1);
    repeat (4) slot(1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
